pc_sequencer: RTL

Controller that sequences the 32-bit program counter register. Every cycle it selects the next fetch address from five sources: boot vector, exception vector, branch target, jump target or sequential PC+4. It drives the PC register's next-address input and write enable. It gates updates on pipeline stalls and instruction-memory readiness, holds redirects that arrive while the PC is frozen, and flushes the fetch stage on control-flow changes.

---
 rtl/pc_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects the next fetch address and PC write/flush controls.
// Optional MIPS branch delay slot behaviour is enabled by defining PC_SEQ_DELAY_SLOT_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter logic [31:0] EXC_VECTOR   = 32'h00000180
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCCur,
    input  logic        Stall,
    input  logic        ImemReady,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        ExcReq,
    output logic [31:0] PCNext,
    output logic        PCWrite,
    output logic        Flush,
    output logic [1:0]  SeqState
);

    localparam logic [1:0] StBoot = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StExc  = 2'd3;

`ifdef PC_SEQ_DELAY_SLOT_EN
    localparam logic RedirectFlush = 1'b0;
`else
    localparam logic RedirectFlush = 1'b1;
`endif

    logic [1:0]  state_q, state_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc_seq;

    // Branch beats jump when both arrive together.
    assign redirect        = BranchTaken | Jump;
    assign redirect_target = BranchTaken ? BranchTarget : JumpTarget;
    assign pc_seq          = PCCur + 32'd4;

    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        PCNext        = pc_seq;
        PCWrite       = 1'b0;
        Flush         = 1'b0;

        if (Reset) begin
            PCNext       = RESET_VECTOR;
            state_d      = StBoot;
            pend_valid_d = 1'b0;
        end else begin
            case (state_q)
                StBoot: begin
                    PCNext  = RESET_VECTOR;
                    PCWrite = 1'b1;
                    Flush   = 1'b1;
                    state_d = StRun;
                end
                StRun, StWait: begin
                    if (ExcReq) begin
                        PCNext       = EXC_VECTOR;
                        PCWrite      = 1'b1;
                        Flush        = 1'b1;
                        pend_valid_d = 1'b0;
                        state_d      = StExc;
                    end else if (state_q == StWait || !ImemReady || Stall) begin
                        // Frozen: hold redirects until the PC can be written again.
                        if (redirect) begin
                            pend_valid_d  = 1'b1;
                            pend_target_d = redirect_target;
                        end
                        if (state_q == StWait) begin
                            state_d = ImemReady ? StRun : StWait;
                        end else if (!ImemReady) begin
                            state_d = StWait;
                        end
                    end else if (pend_valid_q) begin
                        PCNext       = pend_target_q;
                        PCWrite      = 1'b1;
                        Flush        = RedirectFlush;
                        pend_valid_d = redirect;
                        if (redirect) begin
                            pend_target_d = redirect_target;
                        end
                    end else if (redirect) begin
                        PCWrite = 1'b1;
                        Flush   = RedirectFlush;
`ifdef PC_SEQ_DELAY_SLOT_EN
                        // Delay slot instruction is fetched first; target follows.
                        pend_valid_d  = 1'b1;
                        pend_target_d = redirect_target;
`else
                        PCNext = redirect_target;
`endif
                    end else begin
                        PCWrite = 1'b1;
                    end
                end
                default: begin
                    Flush   = 1'b1;
                    state_d = StRun;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        state_q       <= state_d;
        pend_valid_q  <= pend_valid_d;
        pend_target_q <= pend_target_d;
    end

    assign SeqState = state_q;

endmodule
